round_controller: RTL
=====================

ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter ROUND_SECONDS, default 60: round length in seconds; loaded into time_left.
REQ-002 Parameter TICKS_PER_SEC, default 20: game ticks per second.
REQ-003 Parameter INTRO_TICKS, default 60: freeze period before each round.
REQ-004 Parameter HOLD_TICKS, default 40: post-round display period.
REQ-005 Parameter ROUNDS_TO_WIN, default 2: round wins that end the match.
REQ-006 Parameter CONFIRM_TICKS, default 40: consecutive ticks a button is held to confirm.
REQ-007 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 game_tick  in  1  single-clk-cycle enable at the game tick rate (20 Hz).
REQ-010 winner  in  2  health-stage result: 00 fighting, 01 P1 KO win, 10 P2 KO win, 11 double KO.
REQ-011 health_1, health_2  in  9 each  current player health, unsigned.
REQ-012 confirm_btn  in  1  level, already debounced.
REQ-013 force_restart  in  1  level, match-restart request.
REQ-014 round_reset  out  1  one-clk pulse restoring positions/health downstream.
REQ-015 round_active  out  1  high only while fighting; gates player inputs.
REQ-016 time_left  out  7  seconds remaining, unsigned.
REQ-017 p1_rounds, p2_rounds  out  2 each  rounds won.
REQ-018 match_winner  out  2  00 none, 01 P1, 10 P2.
REQ-019 phase  out  2  00 INTRO, 01 FIGHT, 10 ROUND_OVER, 11 MATCH_OVER.

Function
REQ-020 All counters and state SHALL advance only on clk edges where game_tick=1, except round_reset generation.
REQ-021 INTRO: round_active=0; after INTRO_TICKS ticks -> FIGHT.
REQ-022 FIGHT: round_active=1; sub-counter counts TICKS_PER_SEC ticks then decrements time_left by 1; time_left SHALL saturate at 0, never wrap.
REQ-023 FIGHT, winner=01/10 on a tick -> ROUND_OVER, increment matching score (saturating at 3).
REQ-024 FIGHT, winner=11 -> ROUND_OVER, no score change.
REQ-025 FIGHT, time_left=0 with winner=00 -> ROUND_OVER; higher health gets the round; equal health credits nobody.
REQ-026 Same tick KO and timeout: winner input SHALL take priority over the health comparison.
REQ-027 winner is sampled only in FIGHT; ignored in every other phase.
REQ-028 ROUND_OVER: round_active=0; after HOLD_TICKS ticks, if either score >= ROUNDS_TO_WIN -> MATCH_OVER and set match_winner; else pulse round_reset, reload time_left=ROUND_SECONDS, clear sub-counter -> INTRO.
REQ-029 MATCH_OVER: outputs frozen; confirm_btn high for CONFIRM_TICKS consecutive ticks -> full restart.
REQ-030 confirm_btn low on any tick clears its hold counter; confirm_btn is ignored outside MATCH_OVER.
REQ-031 force_restart high for CONFIRM_TICKS consecutive ticks in any phase -> full restart; low on any tick clears its counter.
REQ-032 Full restart: scores=0, match_winner=00, time_left=ROUND_SECONDS, one round_reset pulse, phase INTRO; takes effect on the completing tick.
REQ-033 round_reset SHALL be high for exactly one clk cycle, the cycle after the triggering tick edge; never two consecutive cycles.
REQ-034 Both hold counters and the phase counter SHALL saturate, never wrap, between ticks of the same phase.

Reset
REQ-035 reset=1 on a clk edge SHALL force: phase=00, round_active=0, time_left=ROUND_SECONDS, scores=0, match_winner=00, round_reset=0, all counters=0, regardless of game_tick or phase.
REQ-036 reset mid-round SHALL discard partial sub-second, hold and intro counts; first tick after release counts as intro tick 1.

Verification
REQ-037 Reset release, no inputs -> phase 00 for 60 ticks, 01 on tick 60, round_active=1, time_left=60.
REQ-038 FIGHT, winner=01 held -> ROUND_OVER next tick, p1_rounds=1; 40 ticks later one-cycle round_reset, time_left=60, phase 00.
REQ-039 FIGHT, winner=00, health_1=50, health_2=80 for 1200 ticks -> time_left reaches 0, p2_rounds=1; equal health 100/100 -> no credit.
REQ-040 P1 wins two rounds -> after hold, phase 11, match_winner=01; confirm_btn 39 ticks then low -> still 11; 40 ticks -> scores 0, phase 00, one round_reset pulse.
REQ-041 Same tick time_left=0, winner=10, health_1>health_2 -> p2_rounds increments, p1_rounds unchanged.
REQ-042 force_restart held 40 ticks mid-FIGHT with p1_rounds=1 -> scores 0, phase 00; reset asserted mid-ROUND_OVER -> REQ-035 values next cycle.

Source files
------------

// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller
//
// Sequences a fighting-game match: intro freeze, timed fight, post-round hold
// and match-over screen. Scores rounds from the health stage's KO result or,
// on timeout, from the health comparison. Handles the confirm-to-restart hold
// on the match-over screen and a force-restart hold that works in any phase.
// All state advances only on clk edges where game_tick_i is high; the reset
// is synchronous and active high.
//
// Ports
//   clk_i            system clock, rising edge
//   reset_i          synchronous active-high reset
//   game_tick_i      one-cycle enable at the game tick rate
//   winner_i         00 fighting, 01 P1 KO, 10 P2 KO, 11 double KO
//   health_1_i/2_i   current player health (unsigned)
//   confirm_btn_i    debounced confirm level (used on match-over screen only)
//   force_restart_i  match-restart request level
//   round_reset_o    one-cycle pulse restoring positions/health downstream
//   round_active_o   high only while fighting
//   time_left_o      seconds remaining in the round
//   p1_rounds_o/p2_rounds_o  rounds won (saturate at 3)
//   match_winner_o   00 none, 01 P1, 10 P2
//   phase_o          00 INTRO, 01 FIGHT, 10 ROUND_OVER, 11 MATCH_OVER
// -----------------------------------------------------------------------------
module round_controller #(
    parameter int ROUND_SECONDS = 60,
    parameter int TICKS_PER_SEC = 20,
    parameter int INTRO_TICKS   = 60,
    parameter int HOLD_TICKS    = 40,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int CONFIRM_TICKS = 40
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       game_tick_i,
    input  logic [1:0] winner_i,
    input  logic [8:0] health_1_i,
    input  logic [8:0] health_2_i,
    input  logic       confirm_btn_i,
    input  logic       force_restart_i,
    output logic       round_reset_o,
    output logic       round_active_o,
    output logic [6:0] time_left_o,
    output logic [1:0] p1_rounds_o,
    output logic [1:0] p2_rounds_o,
    output logic [1:0] match_winner_o,
    output logic [1:0] phase_o
);

    typedef enum logic [1:0] {
        PH_INTRO      = 2'b00,
        PH_FIGHT      = 2'b01,
        PH_ROUND_OVER = 2'b10,
        PH_MATCH_OVER = 2'b11
    } phase_e;

    // One phase counter serves both the intro freeze and the post-round hold.
    localparam int PCNT_MAX = (INTRO_TICKS > HOLD_TICKS) ? INTRO_TICKS : HOLD_TICKS;
    localparam int PCNT_W   = $clog2(PCNT_MAX + 1);
    localparam int SUB_W    = $clog2(TICKS_PER_SEC + 1);
    localparam int HOLD_W   = $clog2(CONFIRM_TICKS + 1);

    localparam logic [PCNT_W-1:0] INTRO_LAST = PCNT_W'(INTRO_TICKS - 1);
    localparam logic [PCNT_W-1:0] HOLD_LAST  = PCNT_W'(HOLD_TICKS - 1);
    localparam logic [PCNT_W-1:0] PCNT_SAT   = PCNT_W'(PCNT_MAX);
    localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [HOLD_W-1:0] CONF_LAST  = HOLD_W'(CONFIRM_TICKS - 1);
    localparam logic [HOLD_W-1:0] CONF_SAT   = HOLD_W'(CONFIRM_TICKS);
    localparam logic [6:0]        TIME_INIT  = 7'(ROUND_SECONDS);
    localparam logic [1:0]        WIN_SCORE  = 2'(ROUNDS_TO_WIN);

    // Round score increment that sticks at 3 instead of wrapping to 0.
    function automatic logic [1:0] score_inc(input logic [1:0] s);
        return (s == 2'd3) ? 2'd3 : s + 2'd1;
    endfunction

    // Hold-counter increment that sticks at its ceiling.
    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] c);
        return (c == CONF_SAT) ? c : c + HOLD_W'(1);
    endfunction

    phase_e              phase_q, phase_d;
    logic [PCNT_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [SUB_W-1:0]    sub_cnt_q, sub_cnt_d;
    logic [HOLD_W-1:0]   conf_cnt_q, conf_cnt_d;
    logic [HOLD_W-1:0]   force_cnt_q, force_cnt_d;
    logic [6:0]          time_left_q, time_left_d;
    logic [1:0]          p1_rounds_q, p1_rounds_d;
    logic [1:0]          p2_rounds_q, p2_rounds_d;
    logic [1:0]          match_winner_q, match_winner_d;
    logic                round_reset_q, round_reset_d;
    logic                round_active_q, round_active_d;
    logic                rr_set_s;
    logic                force_done_s;
    logic                conf_done_s;
    logic                restart_s;

    // A restart completes on the tick that finishes either hold sequence.
    assign force_done_s = game_tick_i & force_restart_i & (force_cnt_q == CONF_LAST);
    assign conf_done_s  = game_tick_i & confirm_btn_i & (phase_q == PH_MATCH_OVER)
                        & (conf_cnt_q == CONF_LAST);
    assign restart_s    = force_done_s | conf_done_s;

    // Next-state logic for phase, counters, scores and the round_reset request.
    always_comb begin
        phase_d        = phase_q;
        phase_cnt_d    = phase_cnt_q;
        sub_cnt_d      = sub_cnt_q;
        conf_cnt_d     = conf_cnt_q;
        force_cnt_d    = force_cnt_q;
        time_left_d    = time_left_q;
        p1_rounds_d    = p1_rounds_q;
        p2_rounds_d    = p2_rounds_q;
        match_winner_d = match_winner_q;
        rr_set_s       = 1'b0;

        if (!game_tick_i) begin
            phase_d = phase_q;
        end else if (restart_s) begin
            phase_d        = PH_INTRO;
            phase_cnt_d    = '0;
            sub_cnt_d      = '0;
            conf_cnt_d     = '0;
            force_cnt_d    = '0;
            time_left_d    = TIME_INIT;
            p1_rounds_d    = 2'b00;
            p2_rounds_d    = 2'b00;
            match_winner_d = 2'b00;
            rr_set_s       = 1'b1;
        end else begin
            force_cnt_d = force_restart_i ? hold_inc(force_cnt_q) : '0;
            // Confirm only counts on the match-over screen.
            conf_cnt_d  = (confirm_btn_i && (phase_q == PH_MATCH_OVER)) ? hold_inc(conf_cnt_q) : '0;

            case (phase_q)
                PH_INTRO: begin
                    if (phase_cnt_q == INTRO_LAST) begin
                        phase_cnt_d = '0;
                        phase_d     = PH_FIGHT;
                    end else begin
                        phase_cnt_d = (phase_cnt_q == PCNT_SAT) ? phase_cnt_q : phase_cnt_q + PCNT_W'(1);
                    end
                end
                PH_FIGHT: begin
                    // A KO result outranks the timeout health comparison.
                    if (winner_i == 2'b01) begin
                        p1_rounds_d = score_inc(p1_rounds_q);
                        phase_d     = PH_ROUND_OVER;
                    end else if (winner_i == 2'b10) begin
                        p2_rounds_d = score_inc(p2_rounds_q);
                        phase_d     = PH_ROUND_OVER;
                    end else if (winner_i == 2'b11) begin
                        phase_d = PH_ROUND_OVER;
                    end else if (time_left_q == 7'd0) begin
                        phase_d = PH_ROUND_OVER;
                        if (health_1_i > health_2_i) begin
                            p1_rounds_d = score_inc(p1_rounds_q);
                        end else if (health_2_i > health_1_i) begin
                            p2_rounds_d = score_inc(p2_rounds_q);
                        end else begin
                            p1_rounds_d = p1_rounds_q;
                        end
                    end else if (sub_cnt_q == SUB_LAST) begin
                        sub_cnt_d   = '0;
                        time_left_d = (time_left_q == 7'd0) ? 7'd0 : time_left_q - 7'd1;
                    end else begin
                        sub_cnt_d = sub_cnt_q + SUB_W'(1);
                    end
                end
                PH_ROUND_OVER: begin
                    if (phase_cnt_q == HOLD_LAST) begin
                        phase_cnt_d = '0;
                        if ((p1_rounds_q >= WIN_SCORE) || (p2_rounds_q >= WIN_SCORE)) begin
                            phase_d        = PH_MATCH_OVER;
                            match_winner_d = (p1_rounds_q >= WIN_SCORE) ? 2'b01 : 2'b10;
                        end else begin
                            phase_d     = PH_INTRO;
                            time_left_d = TIME_INIT;
                            sub_cnt_d   = '0;
                            rr_set_s    = 1'b1;
                        end
                    end else begin
                        phase_cnt_d = (phase_cnt_q == PCNT_SAT) ? phase_cnt_q : phase_cnt_q + PCNT_W'(1);
                    end
                end
                PH_MATCH_OVER: begin
                    phase_d = PH_MATCH_OVER;
                end
                default: begin
                    phase_d = PH_INTRO;
                end
            endcase
        end

        // The pulse is never allowed to stretch into a second cycle.
        round_reset_d  = rr_set_s & ~round_reset_q;
        round_active_d = (phase_d == PH_FIGHT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q        <= PH_INTRO;
            phase_cnt_q    <= '0;
            sub_cnt_q      <= '0;
            conf_cnt_q     <= '0;
            force_cnt_q    <= '0;
            time_left_q    <= TIME_INIT;
            p1_rounds_q    <= 2'b00;
            p2_rounds_q    <= 2'b00;
            match_winner_q <= 2'b00;
            round_reset_q  <= 1'b0;
            round_active_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            phase_cnt_q    <= phase_cnt_d;
            sub_cnt_q      <= sub_cnt_d;
            conf_cnt_q     <= conf_cnt_d;
            force_cnt_q    <= force_cnt_d;
            time_left_q    <= time_left_d;
            p1_rounds_q    <= p1_rounds_d;
            p2_rounds_q    <= p2_rounds_d;
            match_winner_q <= match_winner_d;
            round_reset_q  <= round_reset_d;
            round_active_q <= round_active_d;
        end
    end

    assign round_reset_o  = round_reset_q;
    assign round_active_o = round_active_q;
    assign time_left_o    = time_left_q;
    assign p1_rounds_o    = p1_rounds_q;
    assign p2_rounds_o    = p2_rounds_q;
    assign match_winner_o = match_winner_q;
    assign phase_o        = phase_q;

endmodule
